// File: rtl/instruction_fetch_stage_if.sv
// Bus between the fetch stage and its surroundings: the instruction memory port,
// the hazard/redirect controls coming from downstream, and the IF/ID register outputs.
interface instruction_fetch_stage_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      imem_addr;
    logic [31:0]      inst_in;
    logic             stall;
    logic             redirect_valid;
    logic [31:0]      redirect_target;
    logic             halt_req;
    logic             resume;
    logic [31:0]      pc;
    logic [31:0]      if_id_inst;
    logic [31:0]      if_id_pc4;
    logic             if_id_valid;
    logic             misalign_err;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        output imem_addr, pc, if_id_inst, if_id_pc4, if_id_valid, misalign_err, fetch_count,
        input  inst_in, stall, redirect_valid, redirect_target, halt_req, resume
    );

    modport slave (
        input  imem_addr, pc, if_id_inst, if_id_pc4, if_id_valid, misalign_err, fetch_count,
        output inst_in, stall, redirect_valid, redirect_target, halt_req, resume
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, addresses instruction memory and loads the IF/ID register.
// A single registered FSM sequences the one-cycle boot, normal fetching and the halted state.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    instruction_fetch_stage_if.master   bus
);
    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_t;

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      inst_q;
    logic [31:0]      pc4_q;
    logic             valid_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0] pcPlus4;
    logic [31:0] alignedTarget;
    logic        targetMisaligned;

    assign pcPlus4          = pc_q + 32'd4;
    assign alignedTarget    = bus.redirect_target & ~32'h3;
    assign targetMisaligned = |bus.redirect_target[1:0];

    // Redirect outranks halt and stall; while halted only redirect and resume are honoured,
    // and a redirect in the same cycle as resume keeps the stage halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                BOOT: begin
                    valid_q <= 1'b0;
                    state_q <= RUN;
                end
                RUN: begin
                    if (bus.redirect_valid) begin
                        pc_q    <= alignedTarget;
                        inst_q  <= NOP_INST;
                        valid_q <= 1'b0;
                        err_q   <= err_q | targetMisaligned;
                    end else if (bus.halt_req) begin
                        state_q <= HALTED;
                        inst_q  <= NOP_INST;
                        valid_q <= 1'b0;
                    end else if (!bus.stall) begin
                        inst_q  <= bus.inst_in;
                        pc4_q   <= pcPlus4;
                        valid_q <= 1'b1;
                        pc_q    <= pcPlus4;
                        if (!(&cnt_q)) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                HALTED: begin
                    valid_q <= 1'b0;
                    if (bus.redirect_valid) begin
                        pc_q  <= alignedTarget;
                        err_q <= err_q | targetMisaligned;
                    end else if (bus.resume && !bus.halt_req) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= BOOT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_addr    = pc_q;
    assign bus.pc           = pc_q;
    assign bus.if_id_inst   = inst_q;
    assign bus.if_id_pc4    = pc4_q;
    assign bus.if_id_valid  = valid_q;
    assign bus.misalign_err = err_q;
    assign bus.fetch_count  = cnt_q;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Drives two fetch stages (default parameters, and a wrapping PC with a 2-bit counter)
// with directed and random stimulus, comparing both against a behavioural model every cycle.
module tb_instruction_fetch_stage;
    logic clk;
    logic rst;

    instruction_fetch_stage_if #(.CNT_W(32)) ifA ();
    instruction_fetch_stage_if #(.CNT_W(2))  ifB ();

    instruction_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000), .CNT_W(32)) uA (
        .clk (clk),
        .rst (rst),
        .bus (ifA)
    );

    instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(32'h0000_0000), .CNT_W(2)) uB (
        .clk (clk),
        .rst (rst),
        .bus (ifB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: two fixed words at the bottom, a hash elsewhere.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h8C22_0000;
        if (addr == 32'h4) return 32'h0022_1820;
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign ifA.inst_in = memWord(ifA.imem_addr);
    assign ifB.inst_in = memWord(ifB.imem_addr);

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] mPc    [2];
    logic [31:0] mInst  [2];
    logic [31:0] mPc4   [2];
    logic        mValid [2];
    logic        mErr   [2];
    longint      mCnt   [2];
    bit          mBoot  [2];
    bit          mHalt  [2];

    logic [31:0] resetPcOf [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
    longint      cntMaxOf  [2] = '{64'hFFFF_FFFF, 64'd3};

    // Model: what each stage must hold after one clock edge with the given inputs.
    task automatic modelStep(input int k, input bit r, input bit st, input bit rv,
                             input logic [31:0] rt, input bit hr, input bit res);
        if (r) begin
            mPc[k] = resetPcOf[k]; mInst[k] = 32'h0; mPc4[k] = 32'h0;
            mValid[k] = 1'b0; mErr[k] = 1'b0; mCnt[k] = 0; mBoot[k] = 1; mHalt[k] = 0;
        end else if (mBoot[k]) begin
            mBoot[k] = 0; mValid[k] = 1'b0;
        end else if (mHalt[k]) begin
            mValid[k] = 1'b0;
            if (rv) begin
                mPc[k] = {rt[31:2], 2'b00};
                mErr[k] = mErr[k] | (rt[1:0] != 2'b00);
            end else if (res && !hr) begin
                mHalt[k] = 0;
            end
        end else if (rv) begin
            mPc[k] = {rt[31:2], 2'b00}; mInst[k] = 32'h0; mValid[k] = 1'b0;
            mErr[k] = mErr[k] | (rt[1:0] != 2'b00);
        end else if (hr) begin
            mHalt[k] = 1; mValid[k] = 1'b0; mInst[k] = 32'h0;
        end else if (!st) begin
            mInst[k] = memWord(mPc[k]);
            mPc4[k] = mPc[k] + 32'd4;
            mValid[k] = 1'b1;
            mPc[k] = mPc[k] + 32'd4;
            if (mCnt[k] < cntMaxOf[k]) mCnt[k] = mCnt[k] + 1;
        end
    endtask

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("A.imem_addr", {32'h0, ifA.imem_addr},   {32'h0, mPc[0]});
        checkVal("A.pc",        {32'h0, ifA.pc},          {32'h0, mPc[0]});
        checkVal("A.inst",      {32'h0, ifA.if_id_inst},  {32'h0, mInst[0]});
        checkVal("A.pc4",       {32'h0, ifA.if_id_pc4},   {32'h0, mPc4[0]});
        checkVal("A.valid",     {63'h0, ifA.if_id_valid}, {63'h0, mValid[0]});
        checkVal("A.err",       {63'h0, ifA.misalign_err},{63'h0, mErr[0]});
        checkVal("A.count",     {32'h0, ifA.fetch_count}, mCnt[0]);
        checkVal("B.imem_addr", {32'h0, ifB.imem_addr},   {32'h0, mPc[1]});
        checkVal("B.pc",        {32'h0, ifB.pc},          {32'h0, mPc[1]});
        checkVal("B.inst",      {32'h0, ifB.if_id_inst},  {32'h0, mInst[1]});
        checkVal("B.pc4",       {32'h0, ifB.if_id_pc4},   {32'h0, mPc4[1]});
        checkVal("B.valid",     {63'h0, ifB.if_id_valid}, {63'h0, mValid[1]});
        checkVal("B.err",       {63'h0, ifB.misalign_err},{63'h0, mErr[1]});
        checkVal("B.count",     {62'h0, ifB.fetch_count}, mCnt[1]);
    endtask

    // One clock: drive inputs after a falling edge, advance the model, check at the next falling edge.
    task automatic applyStimulus(input bit r, input bit st, input bit rv,
                                 input logic [31:0] rt, input bit hr, input bit res);
        rst = r;
        ifA.stall = st; ifA.redirect_valid = rv; ifA.redirect_target = rt;
        ifA.halt_req = hr; ifA.resume = res;
        ifB.stall = st; ifB.redirect_valid = rv; ifB.redirect_target = rt;
        ifB.halt_req = hr; ifB.resume = res;
        for (int k = 0; k < 2; k++) modelStep(k, r, st, rv, rt, hr, res);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        ifA.stall = 0; ifA.redirect_valid = 0; ifA.redirect_target = 0; ifA.halt_req = 0; ifA.resume = 0;
        ifB.stall = 0; ifB.redirect_valid = 0; ifB.redirect_target = 0; ifB.halt_req = 0; ifB.resume = 0;
        @(negedge clk);

        // Reset, boot cycle, first two fetches
        applyStimulus(1, 0, 0, 32'h0, 0, 0);
        applyStimulus(1, 0, 0, 32'h0, 0, 0);
        checkVal("lit.reset.pcB", {32'h0, ifB.pc}, 64'hFFFF_FFFC);
        checkVal("lit.reset.cnt", {32'h0, ifA.fetch_count}, 64'd0);
        idle(1);
        checkVal("lit.boot.valid", {63'h0, ifA.if_id_valid}, 64'd0);
        checkVal("lit.boot.pc", {32'h0, ifA.pc}, 64'd0);
        idle(1);
        checkVal("lit.f0.inst", {32'h0, ifA.if_id_inst}, 64'h8C22_0000);
        checkVal("lit.f0.pc4", {32'h0, ifA.if_id_pc4}, 64'd4);
        checkVal("lit.f0.pcB", {32'h0, ifB.pc}, 64'd0);
        checkVal("lit.f0.pc4B", {32'h0, ifB.if_id_pc4}, 64'd0);
        idle(1);
        checkVal("lit.f1.inst", {32'h0, ifA.if_id_inst}, 64'h0022_1820);
        checkVal("lit.f1.pc4", {32'h0, ifA.if_id_pc4}, 64'd8);

        // Stall for three cycles, then release
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 32'h0, 0, 0);
        checkVal("lit.stall.pc", {32'h0, ifA.pc}, 64'd8);
        checkVal("lit.stall.cnt", {32'h0, ifA.fetch_count}, 64'd2);
        idle(1);
        checkVal("lit.rel.pc", {32'h0, ifA.pc}, 64'd12);
        checkVal("lit.rel.inst", {32'h0, ifA.if_id_inst}, {32'h0, memWord(32'h8)});
        checkVal("lit.rel.cntB", {62'h0, ifB.fetch_count}, 64'd3);

        // Redirect beats stall and halt; halt follows next cycle
        applyStimulus(0, 1, 1, 32'h40, 1, 0);
        checkVal("lit.pri.pc", {32'h0, ifA.pc}, 64'h40);
        checkVal("lit.pri.valid", {63'h0, ifA.if_id_valid}, 64'd0);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);

        // Misaligned redirect while halted, then an aligned redirect after resuming
        applyStimulus(0, 0, 1, 32'h43, 0, 0);
        checkVal("lit.mis.pc", {32'h0, ifA.pc}, 64'h40);
        checkVal("lit.mis.err", {63'h0, ifA.misalign_err}, 64'd1);
        applyStimulus(0, 0, 0, 32'h0, 0, 1);
        applyStimulus(0, 0, 1, 32'h10, 0, 0);
        checkVal("lit.mis.sticky", {63'h0, ifA.misalign_err}, 64'd1);

        // Halt at 0x10, redirect while halted, resume from 0x80
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        applyStimulus(0, 0, 1, 32'h80, 0, 0);
        checkVal("lit.halt.pc", {32'h0, ifA.pc}, 64'h80);
        applyStimulus(0, 0, 0, 32'h0, 0, 1);
        idle(1);
        checkVal("lit.res.pc4", {32'h0, ifA.if_id_pc4}, 64'h84);
        checkVal("lit.res.valid", {63'h0, ifA.if_id_valid}, 64'd1);
        checkVal("lit.res.cntB", {62'h0, ifB.fetch_count}, 64'd3);

        // Reset mid-run returns to reset values and repeats the boot cycle
        idle(3);
        applyStimulus(1, 0, 0, 32'h0, 0, 0);
        checkVal("lit.rst2.pcB", {32'h0, ifB.pc}, 64'hFFFF_FFFC);
        checkVal("lit.rst2.err", {63'h0, ifA.misalign_err}, 64'd0);
        idle(1);
        checkVal("lit.boot2.valid", {63'h0, ifB.if_id_valid}, 64'd0);
        idle(1);
        checkVal("lit.wrap.pcB", {32'h0, ifB.pc}, 64'd0);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = $urandom_range(0, 3) == 0 ? $urandom() : ($urandom() & 32'h0000_0FFC);
            applyStimulus($urandom_range(0, 63) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 7) == 0,
                          tgt,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
